// File: rtl/pot_scan_sched_if.sv
// pot_scan_sched_if
//   Conversion handshake between the pot scan scheduler and the A2D SPI
//   front end.
//   strt_cnv  : one-cycle conversion request (scheduler -> A2D)
//   chnnl     : A2D channel for the current request (scheduler -> A2D)
//   cnv_cmplt : one-cycle conversion-done strobe (A2D -> scheduler)
//   res       : 12-bit result, valid only while cnv_cmplt=1 (A2D -> scheduler)
interface pot_scan_sched_if;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;

    modport master (output strt_cnv, output chnnl, input cnv_cmplt, input res);
    modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output res);
endinterface

// File: rtl/pot_scan_sched.sv
// pot_scan_sched
//   Sequences the Equalizer slide-pot A2D conversions. Six slots are
//   requested round-robin (LP, B1, B2, B3, HP, VOL) and each 12-bit result
//   is latched into its holding register. Scans start every SCAN_PERIOD
//   clocks. A slot whose conversion never completes is abandoned after
//   TIMEOUT clocks and flagged in timeout_err.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   enable       : scanning permitted
//   a2d          : strt_cnv/chnnl/cnv_cmplt/res handshake (master side)
//   lp_pot..volume : latched pot values
//   pots_vld     : sticky, set once a scan completes its volume slot
//   scan_done    : one-cycle pulse at the end of each scan
//   timeout_err  : sticky timeout flag, cleared by clr_err (set wins)
//   clr_err      : clears timeout_err
module pot_scan_sched #(
    parameter int SCAN_PERIOD = 4096,
    parameter int TIMEOUT     = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    pot_scan_sched_if.master        a2d,
    output logic [11:0]             lp_pot,
    output logic [11:0]             b1_pot,
    output logic [11:0]             b2_pot,
    output logic [11:0]             b3_pot,
    output logic [11:0]             hp_pot,
    output logic [11:0]             volume,
    output logic                    pots_vld,
    output logic                    scan_done,
    output logic                    timeout_err,
    input  logic                    clr_err
);
    localparam int PW = $clog2(SCAN_PERIOD);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_PERIOD - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

    state_t        state_q, state_d;
    logic [2:0]    slot_q, slot_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          strt_q, strt_d;
    logic [2:0]    chnnl_q, chnnl_d;
    logic          vld_q, vld_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [11:0]   pot_q [6];

    logic          cmplt_ev;
    logic          tmo_ev;
    logic          slot_end;

    // Board wiring of the pots onto the A2D mux.
    function automatic logic [2:0] slot_to_ch(input logic [2:0] s);
        case (s)
            3'd0:    return 3'd1;
            3'd1:    return 3'd0;
            3'd2:    return 3'd4;
            3'd3:    return 3'd2;
            3'd4:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    // A completion in the last timeout cycle wins over the timeout.
    assign cmplt_ev = (state_q == WAIT) && a2d.cnv_cmplt;
    assign tmo_ev   = (state_q == WAIT) && !a2d.cnv_cmplt && (tcnt_q == T_LAST);
    assign slot_end = cmplt_ev || tmo_ev;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            slot_q  <= '0;
            pcnt_q  <= '0;
            tcnt_q  <= '0;
            strt_q  <= 1'b0;
            chnnl_q <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < 6; i++) pot_q[i] <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            pcnt_q  <= pcnt_d;
            tcnt_q  <= tcnt_d;
            strt_q  <= strt_d;
            chnnl_q <= chnnl_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (cmplt_ev) pot_q[slot_q] <= a2d.res;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        tcnt_d  = tcnt_q;
        // Period counter runs whenever scanning and saturates so that an
        // overrunning scan restarts straight out of HOLD.
        pcnt_d  = (state_q != IDLE && pcnt_q != P_LAST) ? pcnt_q + 1'b1 : pcnt_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    slot_d  = '0;
                    pcnt_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                tcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (slot_end) begin
                    if (slot_q == 3'd5) begin
                        state_d = HOLD;
                    end else if (!enable) begin
                        state_d = IDLE;
                    end else begin
                        slot_d  = slot_q + 3'd1;
                        state_d = START;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (pcnt_q >= P_LAST) begin
                    slot_d  = '0;
                    pcnt_d  = '0;
                    state_d = START;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic (registered outputs are computed from the next state)
    always_comb begin
        strt_d  = (state_d == START);
        chnnl_d = (state_d == START) ? slot_to_ch(slot_d) : chnnl_q;
        done_d  = slot_end && (slot_q == 3'd5);
        vld_d   = vld_q || (cmplt_ev && (slot_q == 3'd5));
        if (tmo_ev)       err_d = 1'b1;
        else if (clr_err) err_d = 1'b0;
        else              err_d = err_q;
    end

    assign a2d.strt_cnv = strt_q;
    assign a2d.chnnl    = chnnl_q;
    assign lp_pot       = pot_q[0];
    assign b1_pot       = pot_q[1];
    assign b2_pot       = pot_q[2];
    assign b3_pot       = pot_q[3];
    assign hp_pot       = pot_q[4];
    assign volume       = pot_q[5];
    assign pots_vld     = vld_q;
    assign scan_done    = done_q;
    assign timeout_err  = err_q;
endmodule

// File: tb/tb_pot_scan_sched.sv
`timescale 1ns/1ps
module tb_pot_scan_sched;
    localparam int SP = 4096;
    localparam int TO = 1024;
    localparam logic [2:0] CHMAP [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic clr_err = 1'b0;
    logic [11:0] lp_pot, b1_pot, b2_pot, b3_pot, hp_pot, volume;
    logic pots_vld, scan_done, timeout_err;
    logic [11:0] dpot [6];

    pot_scan_sched_if a2d();

    always #5 clk = ~clk;

    pot_scan_sched #(.SCAN_PERIOD(SP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .a2d(a2d),
        .lp_pot(lp_pot), .b1_pot(b1_pot), .b2_pot(b2_pot), .b3_pot(b3_pot),
        .hp_pot(hp_pot), .volume(volume), .pots_vld(pots_vld),
        .scan_done(scan_done), .timeout_err(timeout_err), .clr_err(clr_err)
    );

    assign dpot[0] = lp_pot;
    assign dpot[1] = b1_pot;
    assign dpot[2] = b2_pot;
    assign dpot[3] = b3_pot;
    assign dpot[4] = hp_pot;
    assign dpot[5] = volume;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model (time-based) ----------------
    typedef enum {M_IDLE, M_BUSY, M_HOLD} mmode_t;
    mmode_t      m_mode = M_IDLE;
    int          m_slot = 0;
    int          req_t  = 0;
    int          scan_t = 0;
    int          done_t = 0;
    logic [11:0] m_pot [6] = '{default: 12'h000};
    logic [2:0]  m_ch   = 3'd0;
    logic        m_strt = 1'b0;
    logic        m_done = 1'b0;
    logic        m_vld  = 1'b0;
    logic        m_err  = 1'b0;

    task model_issue(input int t);
        m_strt = 1'b1;
        m_ch   = CHMAP[m_slot];
        req_t  = t;
        m_mode = M_BUSY;
    endtask

    // Decides at each edge from the inputs of the cycle just ended.
    always @(posedge clk) begin : model
        int now;
        int next_start;
        bit fin;
        bit tmo;
        now = cyc;
        fin = 1'b0;
        tmo = 1'b0;
        m_strt = 1'b0;
        m_done = 1'b0;
        if (rst) begin
            m_mode = M_IDLE;
            m_slot = 0;
            for (int i = 0; i < 6; i++) m_pot[i] = 12'h000;
            m_ch  = 3'd0;
            m_vld = 1'b0;
            m_err = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: if (enable) begin
                    m_slot = 0;
                    scan_t = now + 1;
                    model_issue(now + 1);
                end
                M_BUSY: if (now > req_t) begin
                    if (a2d.cnv_cmplt) begin
                        m_pot[m_slot] = a2d.res;
                        fin = 1'b1;
                    end else if (now == req_t + TO) begin
                        tmo = 1'b1;
                        fin = 1'b1;
                    end
                end
                M_HOLD: begin
                    next_start = (scan_t + SP > done_t + 2) ? scan_t + SP : done_t + 2;
                    if (!enable) m_mode = M_IDLE;
                    else if (now + 1 >= next_start) begin
                        m_slot = 0;
                        scan_t = now + 1;
                        model_issue(now + 1);
                    end
                end
                default: m_mode = M_IDLE;
            endcase
            if (fin) begin
                if (m_slot == 5) begin
                    m_done = 1'b1;
                    if (!tmo) m_vld = 1'b1;
                    m_mode = M_HOLD;
                    done_t = now;
                end else if (!enable) begin
                    m_mode = M_IDLE;
                end else begin
                    m_slot = m_slot + 1;
                    model_issue(now + 1);
                end
            end
            if (tmo) m_err = 1'b1;
            else if (clr_err) m_err = 1'b0;
        end
        cyc = cyc + 1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("strt_cnv", 32'(a2d.strt_cnv), 32'(m_strt));
            check("chnnl", 32'(a2d.chnnl), 32'(m_ch));
            check("scan_done", 32'(scan_done), 32'(m_done));
            check("pots_vld", 32'(pots_vld), 32'(m_vld));
            check("timeout_err", 32'(timeout_err), 32'(m_err));
            for (int i = 0; i < 6; i++)
                check($sformatf("pot%0d", i), 32'(dpot[i]), 32'(m_pot[i]));
        end
    end

    // ---------------- event log ----------------
    int strt_tq [$];
    int strt_chq [$];
    int done_tq [$];

    always @(negedge clk) begin
        if (a2d.strt_cnv === 1'b1) begin
            strt_tq.push_back(cyc);
            strt_chq.push_back(int'(a2d.chnnl));
        end
        if (scan_done === 1'b1) done_tq.push_back(cyc);
    end

    // ---------------- A2D responder ----------------
    int          a_cnt = 0;
    bit          a_pend = 1'b0;
    logic [2:0]  a_ch = 3'd0;
    int          lat_lo = 10;
    int          lat_hi = 10;
    int          withhold_ch = -1;
    int          hold_pct = 0;
    int          stray_pct = 0;
    bit          rand_res = 1'b0;
    logic [11:0] res_base = 12'h100;
    int          stray_req = 0;
    int          stray_ack = 0;

    always @(negedge clk) begin
        a2d.cnv_cmplt = 1'b0;
        if (stray_req != stray_ack) begin
            stray_ack = stray_req;
            a2d.cnv_cmplt = 1'b1;
            a2d.res = 12'hFFF;
            a_pend = 1'b0;
        end else if (a_pend) begin
            if (a_cnt <= 1) begin
                a2d.cnv_cmplt = 1'b1;
                a2d.res = rand_res ? 12'($urandom) : res_base + 12'(a_ch);
                a_pend = 1'b0;
            end else begin
                a_cnt = a_cnt - 1;
            end
        end else if (stray_pct != 0 && int'($urandom_range(99)) < stray_pct) begin
            a2d.cnv_cmplt = 1'b1;
            a2d.res = 12'($urandom);
        end
        if (a2d.strt_cnv === 1'b1) begin
            a_ch   = a2d.chnnl;
            a_pend = !((int'(a_ch) == withhold_ch) ||
                       (hold_pct != 0 && int'($urandom_range(99)) < hold_pct));
            a_cnt  = int'($urandom_range(lat_hi, lat_lo));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_strt(input int n, input int budget, input string what);
        int k = 0;
        while (strt_tq.size() < n && k < budget) begin step(); k++; end
        check(what, 32'(strt_tq.size() >= n), 32'd1);
    endtask

    task automatic wait_done(input int n, input int budget, input string what);
        int k = 0;
        while (done_tq.size() < n && k < budget) begin step(); k++; end
        check(what, 32'(done_tq.size() >= n), 32'd1);
    endtask

    int exp_seq [6] = '{1, 0, 4, 2, 3, 7};
    int off_cnt = 0;
    int n0 = 0;
    int d0 = 0;

    initial begin
        step();
        chk_en = 1'b1;
        step();
        check("rst strt_cnv", 32'(a2d.strt_cnv), 32'd0);
        check("rst chnnl", 32'(a2d.chnnl), 32'd0);
        check("rst pots_vld", 32'(pots_vld), 32'd0);
        check("rst scan_done", 32'(scan_done), 32'd0);
        check("rst timeout_err", 32'(timeout_err), 32'd0);
        check("rst volume", 32'(volume), 32'd0);
        rst = 1'b0;

        // First scan: fixed 10-cycle latency, res = 0x100 + channel
        enable = 1'b1;
        wait_done(1, 6000, "first scan_done");
        for (int i = 0; i < 6; i++) check("chnnl sequence", 32'(strt_chq[i]), 32'(exp_seq[i]));
        check("lp_pot", 32'(lp_pot), 32'h101);
        check("b1_pot", 32'(b1_pot), 32'h100);
        check("b2_pot", 32'(b2_pot), 32'h104);
        check("b3_pot", 32'(b3_pot), 32'h102);
        check("hp_pot", 32'(hp_pot), 32'h103);
        check("volume", 32'(volume), 32'h107);
        check("pots_vld after scan", 32'(pots_vld), 32'd1);
        check("scan length", 32'(done_tq[0] - strt_tq[0]), 32'd66);

        // Period spacing, then withhold ch4 in the second scan
        wait_strt(7, 5000, "second scan start");
        check("scan period", 32'(strt_tq[6] - strt_tq[0]), 32'(SP));
        check("slot0 channel", 32'(strt_chq[6]), 32'd1);
        check("one scan_done per period", 32'(done_tq.size()), 32'd1);
        withhold_ch = 4;
        wait_strt(10, 1500, "request after timeout");
        check("timeout channel", 32'(strt_chq[8]), 32'd4);
        check("timeout gap", 32'(strt_tq[9] - strt_tq[8]), 32'(TO + 1));
        check("b2 kept on timeout", 32'(b2_pot), 32'h104);
        check("timeout_err set", 32'(timeout_err), 32'd1);
        withhold_ch = -1;
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("timeout_err cleared", 32'(timeout_err), 32'd0);

        // Drop enable during the ch4 WAIT of the third scan
        wait_strt(13, 5000, "third scan start");
        res_base = 12'h200;
        wait_strt(15, 100, "third scan ch4");
        check("ch4 request", 32'(strt_chq[14]), 32'd4);
        enable = 1'b0;
        repeat (30) step();
        check("ch4 latched after disable", 32'(b2_pot), 32'h204);
        check("b3 untouched after disable", 32'(b3_pot), 32'h102);
        check("no request while idle", 32'(strt_tq.size()), 32'd15);
        enable = 1'b1;
        wait_strt(16, 10, "restart request");
        check("restart on ch1", 32'(strt_chq[15]), 32'd1);

        // Reset mid-scan, then a stray strobe with 0xFFF
        repeat (3) step();
        rst = 1'b1;
        enable = 1'b0;
        step();
        rst = 1'b0;
        stray_req = stray_req + 1;
        repeat (30) step();
        for (int i = 0; i < 6; i++) check("pot zero after reset", 32'(dpot[i]), 32'd0);
        check("pots_vld after reset", 32'(pots_vld), 32'd0);
        check("no request after reset", 32'(strt_tq.size()), 32'd16);

        // Overrun: 700-cycle conversions make a scan longer than the period
        lat_lo = 700;
        lat_hi = 700;
        res_base = 12'h100;
        n0 = strt_tq.size();
        d0 = done_tq.size();
        enable = 1'b1;
        wait_done(d0 + 1, 6000, "overrun scan_done");
        wait_strt(n0 + 7, 100, "overrun restart");
        check("overrun restart gap", 32'(strt_tq[n0 + 6] - done_tq[d0]), 32'd1);
        check("overrun scan spacing", 32'(strt_tq[n0 + 6] - strt_tq[n0]), 32'd4207);

        // Randomized traffic
        lat_lo = 1;
        lat_hi = 40;
        hold_pct = 3;
        stray_pct = 1;
        rand_res = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            step();
            if (off_cnt > 0) begin
                off_cnt = off_cnt - 1;
                if (off_cnt == 0) enable = 1'b1;
            end else if ($urandom_range(1999) == 0) begin
                enable = 1'b0;
                off_cnt = int'($urandom_range(30, 1));
            end
            clr_err = ($urandom_range(199) == 0);
        end
        clr_err = 1'b0;
        enable = 1'b0;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
